// File: rtl/vending_core_param_if.sv
// Request/response bundle for vending_core_param.
// master drives the request strobes; slave is the transaction core.
interface vending_core_param_if #(
    parameter int PROD_W  = 3,
    parameter int QTY_W   = 4,
    parameter int MONEY_W = 4,
    parameter int BANK_W  = 8
);
    logic               costumer_mode;
    logic               owner_supply_mode;
    logic               owner_money_mode;
    logic [PROD_W-1:0]  product;
    logic [MONEY_W-1:0] costumer_money;
    logic [QTY_W-1:0]   quantitiy;
    logic               busy;
    logic               done;
    logic [2:0]         status;
    logic [BANK_W-1:0]  out_amount;
    logic [QTY_W-1:0]   stock_level;
    logic [BANK_W-1:0]  bank;
    logic [6:0]         seg1;
    logic [6:0]         seg2;

    modport master (
        output costumer_mode, owner_supply_mode, owner_money_mode,
        output product, costumer_money, quantitiy,
        input  busy, done, status, out_amount, stock_level, bank,
        input  seg1, seg2
    );

    modport slave (
        input  costumer_mode, owner_supply_mode, owner_money_mode,
        input  product, costumer_money, quantitiy,
        output busy, done, status, out_amount, stock_level, bank,
        output seg1, seg2
    );
endinterface

// File: rtl/vending_core_param.sv
// Vending transaction core: stock, price ladder, cash bank, change/payout.
// Define VEND_SEG_EN to enable the 7-segment decode of out_amount.
module vending_core_param #(
    parameter int PROD_W     = 3,
    parameter int QTY_W      = 4,
    parameter int MONEY_W    = 4,
    parameter int BANK_W     = 8,
    parameter int PRICE_STEP = 1,
    parameter int STOCK_INIT = 2
) (
    input logic clk,
    input logic rst_n,
    vending_core_param_if.slave bus
);
    localparam int N_PROD = 2**PROD_W;

    localparam logic [2:0] ST_OK   = 3'd0;
    localparam logic [2:0] ST_SOLD = 3'd1;
    localparam logic [2:0] ST_FUND = 3'd2;
    localparam logic [2:0] ST_FULL = 3'd3;
    localparam logic [2:0] ST_SAT  = 3'd4;
    localparam logic [2:0] ST_NONE = 3'd7;

    localparam logic [BANK_W-1:0] ONE_B = BANK_W'(1);
    localparam logic [BANK_W-1:0] STEP  = BANK_W'(PRICE_STEP);
    localparam logic [BANK_W-1:0] BMAX  = '1;
    localparam logic [QTY_W-1:0]  QMAX  = '1;
    localparam logic [QTY_W-1:0]  QINIT = QTY_W'(STOCK_INIT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        OP_BUY,
        OP_FILL,
        OP_PAY
    } op_t;

    state_t             state_q, state_d;
    op_t                op_q, op_d;
    logic [PROD_W-1:0]  prod_q, prod_d;
    logic [MONEY_W-1:0] money_q, money_d;
    logic [QTY_W-1:0]   qty_q, qty_d;
    logic [QTY_W-1:0]   stock_q [N_PROD];
    logic [QTY_W-1:0]   stock_d [N_PROD];
    logic [BANK_W-1:0]  bank_q, bank_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [2:0]         status_q, status_d;
    logic [BANK_W-1:0]  amt_q, amt_d;
    logic [QTY_W-1:0]   lvl_q, lvl_d;

    logic               sel_fill, sel_pay, sel_buy;
    logic [QTY_W-1:0]   cur;
    logic [BANK_W-1:0]  price;
    logic [BANK_W-1:0]  money_x;
    logic [BANK_W:0]    bank_sum;
    logic [QTY_W:0]     fill_sum;

    // One-hot request select: supply beats money beats customer.
    assign sel_fill = bus.owner_supply_mode;
    assign sel_pay  = bus.owner_money_mode & ~sel_fill;
    assign sel_buy  = bus.costumer_mode & ~sel_fill & ~sel_pay;

    assign cur      = stock_q[prod_q];
    assign price    = (BANK_W'(prod_q) + ONE_B) * STEP;
    assign money_x  = BANK_W'(money_q);
    assign bank_sum = {1'b0, bank_q} + {1'b0, price};
    assign fill_sum = {1'b0, cur} + {1'b0, qty_q};

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        prod_d   = prod_q;
        money_d  = money_q;
        qty_d    = qty_q;
        stock_d  = stock_q;
        bank_d   = bank_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        status_d = status_q;
        amt_d    = amt_q;
        lvl_d    = lvl_q;

        unique case (state_q)
            S_IDLE: begin
                if (sel_fill | sel_pay | sel_buy) begin
                    state_d = S_EXEC;
                    busy_d  = 1'b1;
                    prod_d  = bus.product;
                    money_d = bus.costumer_money;
                    qty_d   = bus.quantitiy;
                end
                unique case (1'b1)
                    sel_fill: op_d = OP_FILL;
                    sel_pay:  op_d = OP_PAY;
                    sel_buy:  op_d = OP_BUY;
                    default:  op_d = op_q;
                endcase
            end
            S_EXEC: begin
                state_d = S_DONE;
                done_d  = 1'b1;
                unique case (op_q)
                    OP_BUY: begin
                        lvl_d = cur;
                        amt_d = money_x;
                        if (cur == '0) begin
                            status_d = ST_SOLD;
                        end else if (money_x < price) begin
                            status_d = ST_FUND;
                        end else if (bank_sum > {1'b0, BMAX}) begin
                            status_d = ST_FULL;
                        end else begin
                            status_d        = ST_OK;
                            stock_d[prod_q] = cur - 1'b1;
                            lvl_d           = cur - 1'b1;
                            bank_d          = bank_sum[BANK_W-1:0];
                            amt_d           = money_x - price;
                        end
                    end
                    OP_FILL: begin
                        amt_d = '0;
                        if (fill_sum > {1'b0, QMAX}) begin
                            status_d = ST_SAT;
                            lvl_d    = QMAX;
                        end else begin
                            status_d = ST_OK;
                            lvl_d    = fill_sum[QTY_W-1:0];
                        end
                        stock_d[prod_q] = lvl_d;
                    end
                    OP_PAY: begin
                        status_d = ST_OK;
                        amt_d    = bank_q;
                        bank_d   = '0;
                        lvl_d    = '0;
                    end
                    default: status_d = status_q;
                endcase
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            op_q     <= OP_BUY;
            prod_q   <= '0;
            money_q  <= '0;
            qty_q    <= '0;
            bank_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            status_q <= ST_NONE;
            amt_q    <= '0;
            lvl_q    <= '0;
            for (int i = 0; i < N_PROD; i++) begin
                stock_q[i] <= QINIT;
            end
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            prod_q   <= prod_d;
            money_q  <= money_d;
            qty_q    <= qty_d;
            bank_q   <= bank_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            status_q <= status_d;
            amt_q    <= amt_d;
            lvl_q    <= lvl_d;
            for (int i = 0; i < N_PROD; i++) begin
                stock_q[i] <= stock_d[i];
            end
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.status      = status_q;
    assign bus.out_amount  = amt_q;
    assign bus.stock_level = lvl_q;
    assign bus.bank        = bank_q;

`ifdef VEND_SEG_EN
    localparam logic [6:0] SEG_E = 7'b1111001;

    logic [6:0] seg1_q, seg1_d;
    logic [6:0] seg2_q, seg2_d;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] s;
        unique case (v)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            4'hF: s = 7'h71;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    // Digits latch together with the results, so they hold until next done.
    always_comb begin
        seg1_d = seg1_q;
        seg2_d = seg2_q;
        if (state_q == S_EXEC) begin
            if (status_d == ST_OK) begin
                seg1_d = hex7(amt_d[7:4]);
                seg2_d = hex7(amt_d[3:0]);
            end else begin
                seg1_d = SEG_E;
                seg2_d = SEG_E;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg1_q <= '0;
            seg2_q <= '0;
        end else begin
            seg1_q <= seg1_d;
            seg2_q <= seg2_d;
        end
    end

    assign bus.seg1 = seg1_q;
    assign bus.seg2 = seg2_q;
`else
    assign bus.seg1 = 7'b0;
    assign bus.seg2 = 7'b0;
`endif
endmodule

// File: tb/tb_vending_core_param.sv
// Scoreboard bench for vending_core_param: driver pushes model results,
// monitor pops and compares on every done pulse.
module tb_vending_core_param;
    localparam int PW = 3;
    localparam int QW = 4;
    localparam int MW = 4;
    localparam int BW = 8;
    localparam int NP = 8;
    localparam int QMAX = 15;
    localparam int BMAX = 255;

    typedef struct {
        int st;
        int amt;
        int lvl;
        int bnk;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   done_cnt = 0;
    int   full_seen = 0;
    int   m_stock [NP];
    int   m_bank;
    exp_t sb [$];

    vending_core_param_if #(
        .PROD_W(PW), .QTY_W(QW), .MONEY_W(MW), .BANK_W(BW)
    ) bus ();

    vending_core_param #(
        .PROD_W(PW), .QTY_W(QW), .MONEY_W(MW), .BANK_W(BW),
        .PRICE_STEP(1), .STOCK_INIT(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int seg_of(input int nib);
        int tbl [16] = '{'h3F, 'h06, 'h5B, 'h4F, 'h66, 'h6D, 'h7D, 'h07,
                         'h7F, 'h6F, 'h77, 'h7C, 'h39, 'h5E, 'h79, 'h71};
        return tbl[nib & 15];
    endfunction

    task automatic mdl_reset();
        for (int i = 0; i < NP; i++) m_stock[i] = 2;
        m_bank = 0;
    endtask

    // Reference: one whole transaction at a time, straight from the rules.
    function automatic exp_t mdl(input bit c, input bit s, input bit m,
                                 input int p, input int money, input int qty);
        exp_t e;
        int price;
        price = p + 1;
        if (s) begin
            e.amt = 0;
            if (m_stock[p] + qty > QMAX) begin
                m_stock[p] = QMAX;
                e.st = 4;
            end else begin
                m_stock[p] = m_stock[p] + qty;
                e.st = 0;
            end
            e.lvl = m_stock[p];
        end else if (m) begin
            e.st = 0;
            e.amt = m_bank;
            e.lvl = 0;
            m_bank = 0;
        end else begin
            e.amt = money;
            if (m_stock[p] == 0) e.st = 1;
            else if (money < price) e.st = 2;
            else if (m_bank + price > BMAX) e.st = 3;
            else begin
                e.st = 0;
                m_stock[p]--;
                m_bank += price;
                e.amt = money - price;
            end
            e.lvl = m_stock[p];
        end
        e.bnk = m_bank;
        return e;
    endfunction

    task automatic drive(input bit c, input bit s, input bit m,
                         input int p, input int money, input int qty);
        bus.costumer_mode     = c;
        bus.owner_supply_mode = s;
        bus.owner_money_mode  = m;
        bus.product           = PW'(p);
        bus.costumer_money    = MW'(money);
        bus.quantitiy         = QW'(qty);
    endtask

    task automatic issue(input bit c, input bit s, input bit m,
                         input int p, input int money, input int qty,
                         input bit noise);
        int n;
        @(negedge clk);
        drive(c, s, m, p, money, qty);
        sb.push_back(mdl(c, s, m, p, money, qty));
        @(negedge clk);
        chk("busy_on_accept", int'(bus.busy), 1);
        // Strobes arriving mid-transaction must be dropped.
        if (noise)
            drive($urandom_range(0, 1), $urandom_range(0, 1), 1'b1,
                  $urandom_range(0, 7), $urandom_range(0, 15),
                  $urandom_range(0, 15));
        else
            drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        n = 0;
        while (bus.busy && n < 8) begin
            @(negedge clk);
            n++;
        end
        if (bus.busy) chk("busy_timeout", 1, 0);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                done_cnt++;
                if (bus.status == 3'd3) full_seen++;
                if (sb.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("status", int'(bus.status), e.st);
                    chk("out_amount", int'(bus.out_amount), e.amt);
                    chk("stock_level", int'(bus.stock_level), e.lvl);
                    chk("bank", int'(bus.bank), e.bnk);
                    chk("busy_at_done", int'(bus.busy), 1);
`ifdef VEND_SEG_EN
                    chk("seg1", int'(bus.seg1),
                        e.st == 0 ? seg_of(e.amt >> 4) : 'h79);
                    chk("seg2", int'(bus.seg2),
                        e.st == 0 ? seg_of(e.amt) : 'h79);
`else
                    chk("seg1", int'(bus.seg1), 0);
                    chk("seg2", int'(bus.seg2), 0);
`endif
                end
            end
        end
    end

    initial begin
        bit c, s, m;
        int d0;
        drive(0, 0, 0, 0, 0, 0);
        mdl_reset();
        repeat (3) @(negedge clk);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_status", int'(bus.status), 7);
        chk("rst_amt", int'(bus.out_amount), 0);
        chk("rst_lvl", int'(bus.stock_level), 0);
        chk("rst_bank", int'(bus.bank), 0);
        chk("rst_seg1", int'(bus.seg1), 0);
        rst_n = 1'b1;

        issue(1, 0, 0, 2, 12, 0, 0);
        chk("t1_amt", int'(bus.out_amount), 9);
        chk("t1_bank", int'(bus.bank), 3);
        chk("t1_lvl", int'(bus.stock_level), 1);
        issue(1, 0, 0, 2, 12, 0, 0);
        issue(1, 0, 0, 2, 12, 0, 0);
        chk("t2_status", int'(bus.status), 1);
        chk("t2_amt", int'(bus.out_amount), 12);
        chk("t2_bank", int'(bus.bank), 6);
        issue(1, 0, 0, 7, 5, 0, 1);
        chk("t3_status", int'(bus.status), 2);
        chk("t3_amt", int'(bus.out_amount), 5);
        issue(0, 1, 0, 0, 0, 2, 0);
        chk("t4_lvl", int'(bus.stock_level), 4);
        issue(0, 1, 0, 0, 0, 15, 0);
        chk("t4_sat", int'(bus.status), 4);
        chk("t4_lvl15", int'(bus.stock_level), 15);
        issue(1, 1, 0, 3, 9, 1, 0);
        chk("t5_lvl", int'(bus.stock_level), 3);
        chk("t5_bank", int'(bus.bank), 6);
        issue(0, 0, 1, 0, 0, 0, 0);
        chk("t5_pay", int'(bus.out_amount), 6);
        chk("t5_bank0", int'(bus.bank), 0);

        @(negedge clk);
        drive(1, 0, 0, 1, 9, 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        d0 = done_cnt;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("t6_no_done", done_cnt, d0);
        chk("t6_status", int'(bus.status), 7);
        chk("t6_bank", int'(bus.bank), 0);
        chk("t6_busy", int'(bus.busy), 0);
        mdl_reset();
        for (int i = 0; i < NP; i++) issue(0, 1, 0, i, 0, 0, 0);

        for (int r = 0; r < 5; r++) begin
            issue(0, 1, 0, 7, 0, 15, 0);
            for (int k = 0; k < 8; k++) issue(1, 0, 0, 7, 15, 0, 0);
        end
        chk("bank_full_seen", int'(full_seen > 0), 1);

        for (int i = 0; i < 300; i++) begin
            c = 1'($urandom_range(0, 1));
            s = ($urandom_range(0, 3) == 0);
            m = ($urandom_range(0, 39) == 0);
            if (!c && !s && !m) c = 1'b1;
            issue(c, s, m, $urandom_range(0, 7), $urandom_range(0, 15),
                  $urandom_range(0, 15), 1'($urandom_range(0, 1)));
        end

        repeat (4) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
